// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: UART-to-block-RAM debug bridge.
// Decodes framed byte commands from a UART receiver, performs masked word
// writes or burst reads on a synchronous-read RAM port, and streams read
// data / status bytes back through a valid/ready UART transmitter.
//
// Frames (multi-byte fields LSB first):
//   WRITE 0x0F : addr[ADDR_BYTES] mask[1] data[DATA_BYTES]  -> ACK 0x06
//   READ  0xFF : start[ADDR_BYTES] end[ADDR_BYTES]           -> data bytes, or NAK 0x15
//   PING  0xA5 : no payload                                  -> echo 0xA5
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rx_valid, rx_data     received-byte strobe and byte
//   tx_ready              transmitter accepts tx_data this cycle
//   tx_valid, tx_data     outgoing byte, held until tx_ready
//   mem_addr              word-aligned byte address
//   mem_we, mem_wdata     per-byte write enable pulse and write data
//   mem_re, mem_rdata     read request pulse and read data (RD_LATENCY later)
//   busy                  high whenever the bridge is not idle
module uart_mem_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_BYTES     = 4,
  parameter int RD_LATENCY     = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_BYTES-1:0]   mem_we,
  output logic [8*DATA_BYTES-1:0] mem_wdata,
  output logic                    mem_re,
  input  logic [8*DATA_BYTES-1:0] mem_rdata,
  output logic                    busy
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int WR_LEN     = ADDR_BYTES + 1 + DATA_BYTES;
  localparam int RD_LEN     = 2 * ADDR_BYTES;
  localparam int BUF_BYTES  = (WR_LEN > RD_LEN) ? WR_LEN : RD_LEN;
  // One counter serves payload index, read-latency wait and send index.
  localparam int CNT_W      = $clog2(BUF_BYTES + 8);
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_WR   = 8'h0F;
  localparam logic [7:0] CMD_RD   = 8'hFF;
  localparam logic [7:0] CMD_PING = 8'hA5;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(DATA_BYTES - 1));

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX       = 3'd1,
    S_WR       = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_SEND  = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  state_t                    state_r, state_nxt;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt;
  logic [TMO_W-1:0]          tmo_r, tmo_nxt;
  logic [8*BUF_BYTES-1:0]    buf_r, buf_nxt;
  logic                      is_rd_r, is_rd_nxt;
  logic [ADDR_WIDTH-1:0]     cur_r, cur_nxt;
  logic [ADDR_WIDTH-1:0]     end_r, end_nxt;
  logic [8*DATA_BYTES-1:0]   shift_r, shift_nxt;
  logic [7:0]                resp_r, resp_nxt;
  logic [CNT_W-1:0]          last_idx_s;
  logic [ADDR_WIDTH-1:0]     start_s, stop_s;

  logic                      tx_valid_s;
  logic [7:0]                tx_data_s;
  logic [ADDR_WIDTH-1:0]     mem_addr_s;
  logic [DATA_BYTES-1:0]     mem_we_s;
  logic [8*DATA_BYTES-1:0]   mem_wdata_s;
  logic                      mem_re_s;
  logic                      busy_s;

  // Assemble an address field from the payload buffer and word-align it.
  function automatic logic [ADDR_WIDTH-1:0] field_addr(input logic [8*BUF_BYTES-1:0] b,
                                                       input int first);
    logic [8*ADDR_BYTES-1:0] v;
    v = '0;
    for (int i = 0; i < ADDR_BYTES; i++) begin
      v[8*i +: 8] = b[8*(first + i) +: 8];
    end
    return v[ADDR_WIDTH-1:0] & ALIGN_MASK;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      tmo_r   <= '0;
      buf_r   <= '0;
      is_rd_r <= 1'b0;
      cur_r   <= '0;
      end_r   <= '0;
      shift_r <= '0;
      resp_r  <= 8'h00;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      tmo_r   <= tmo_nxt;
      buf_r   <= buf_nxt;
      is_rd_r <= is_rd_nxt;
      cur_r   <= cur_nxt;
      end_r   <= end_nxt;
      shift_r <= shift_nxt;
      resp_r  <= resp_nxt;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    tmo_nxt    = tmo_r;
    buf_nxt    = buf_r;
    is_rd_nxt  = is_rd_r;
    cur_nxt    = cur_r;
    end_nxt    = end_r;
    shift_nxt  = shift_r;
    resp_nxt   = resp_r;
    last_idx_s = is_rd_r ? CNT_W'(RD_LEN - 1) : CNT_W'(WR_LEN - 1);
    start_s    = '0;
    stop_s     = '0;
    case (state_r)
      S_IDLE: begin
        if (rx_valid && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
          state_nxt = S_RX;
          is_rd_nxt = (rx_data == CMD_RD);
          cnt_nxt   = '0;
          tmo_nxt   = '0;
          buf_nxt   = '0;
        end else if (rx_valid && (rx_data == CMD_PING)) begin
          state_nxt = S_RESP;
          resp_nxt  = CMD_PING;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RX: begin
        if (rx_valid) begin
          for (int i = 0; i < BUF_BYTES; i++) begin
            if (cnt_r == CNT_W'(i)) begin
              buf_nxt[8*i +: 8] = rx_data;
            end else begin
              buf_nxt[8*i +: 8] = buf_r[8*i +: 8];
            end
          end
          cnt_nxt = cnt_r + CNT_W'(1);
          tmo_nxt = '0;
          if (cnt_r == last_idx_s) begin
            if (!is_rd_r) begin
              state_nxt = S_WR;
            end else begin
              // Range check uses the frame including the byte arriving now.
              start_s = field_addr(buf_nxt, 0);
              stop_s  = field_addr(buf_nxt, ADDR_BYTES);
              cur_nxt = start_s;
              end_nxt = stop_s;
              if (start_s > stop_s) begin
                state_nxt = S_RESP;
                resp_nxt  = RSP_NAK;
              end else begin
                state_nxt = S_RD_ISSUE;
              end
            end
          end else begin
            state_nxt = S_RX;
          end
        end else if (tmo_r >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt = tmo_r + TMO_W'(1);
        end
      end
      S_WR: begin
        state_nxt = S_RESP;
        resp_nxt  = RSP_ACK;
      end
      S_RD_ISSUE: begin
        state_nxt = S_RD_WAIT;
        cnt_nxt   = '0;
      end
      S_RD_WAIT: begin
        // Last wait cycle is the one where mem_rdata becomes valid.
        if (cnt_r == CNT_W'(RD_LATENCY - 1)) begin
          shift_nxt = mem_rdata;
          cnt_nxt   = '0;
          state_nxt = S_RD_SEND;
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      S_RD_SEND: begin
        if (tx_valid && tx_ready) begin
          shift_nxt = shift_r >> 4'd8;
          if (cnt_r == CNT_W'(DATA_BYTES - 1)) begin
            cnt_nxt = '0;
            // Equality end test: a burst ending at the top word never wraps.
            if (cur_r == end_r) begin
              state_nxt = S_IDLE;
            end else begin
              cur_nxt   = cur_r + ADDR_WIDTH'(DATA_BYTES);
              state_nxt = S_RD_ISSUE;
            end
          end else begin
            cnt_nxt = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt = S_RD_SEND;
        end
      end
      S_RESP: begin
        if (tx_valid && tx_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RESP;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with state_r.
  always_comb begin
    tx_valid_s  = 1'b0;
    tx_data_s   = 8'h00;
    mem_addr_s  = '0;
    mem_we_s    = '0;
    mem_wdata_s = '0;
    mem_re_s    = 1'b0;
    busy_s      = (state_nxt != S_IDLE);
    case (state_nxt)
      S_WR: begin
        mem_addr_s  = field_addr(buf_nxt, 0);
        mem_we_s    = buf_nxt[8*ADDR_BYTES +: DATA_BYTES];
        mem_wdata_s = buf_nxt[8*(ADDR_BYTES + 1) +: 8*DATA_BYTES];
      end
      S_RD_ISSUE: begin
        mem_re_s   = 1'b1;
        mem_addr_s = cur_nxt;
      end
      S_RD_SEND: begin
        tx_valid_s = 1'b1;
        tx_data_s  = shift_nxt[7:0];
      end
      S_RESP: begin
        tx_valid_s = 1'b1;
        tx_data_s  = resp_nxt;
      end
      default: begin
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_valid  <= tx_valid_s;
      tx_data   <= tx_data_s;
      mem_addr  <= mem_addr_s;
      mem_we    <= mem_we_s;
      mem_wdata <= mem_wdata_s;
      mem_re    <= mem_re_s;
      busy      <= busy_s;
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Testbench for uart_mem_bridge: directed and randomized frames checked
// against a byte-level reference model of the command protocol and a
// shadow copy of the RAM contents.
module tb_uart_mem_bridge;

  localparam int AW  = 16;
  localparam int DB  = 4;
  localparam int RL  = 2;
  localparam int TMO = 200;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic           tx_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic [AW-1:0]  mem_addr;
  logic [DB-1:0]  mem_we;
  logic [31:0]    mem_wdata;
  logic           mem_re;
  logic [31:0]    mem_rdata;
  logic           busy;

  uart_mem_bridge #(
    .ADDR_WIDTH(AW), .DATA_BYTES(DB), .RD_LATENCY(RL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- RAM with RL-cycle read latency ----------------
  logic [31:0] ram     [0:16383];
  logic [31:0] rd_pipe [0:RL-1];
  logic        ram_init;

  function automatic logic [31:0] init_word(input int idx);
    return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // RAM storage, preload and read pipeline (junk when no read is in flight).
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= init_word(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= mem_re ? ram[mem_addr[15:2]] : $urandom;
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  // ---------------- Monitor / tx_ready driver ----------------
  logic [7:0]  tx_log [0:4095];
  logic [51:0] wr_log [0:1023];
  int          tx_n = 0, wr_n = 0, re_n = 0, stab_viol = 0;
  bit          rdy_random = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_n) begin
        if (prev_stall && !(tx_valid && (tx_data == prev_data))) stab_viol++;
        if (tx_valid && tx_ready && tx_n < 4096) begin
          tx_log[tx_n] = tx_data;
          tx_n++;
        end
        if (mem_we != 4'd0 && wr_n < 1024) begin
          wr_log[wr_n] = {mem_addr, mem_we, mem_wdata};
          wr_n++;
        end
        if (mem_re) re_n++;
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- Reference model and checking ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  fr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [51:0] exp_wr_q[$];
  int          exp_re = 0;
  logic [31:0] ref_mem [0:16383];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/idle"}, 64'(busy), 64'd0);
  endtask

  task automatic add_write(input logic [15:0] a, input logic [7:0] m, input logic [31:0] d);
    logic [63:0] f;
    logic [15:0] al;
    f  = {d, m, a, 8'h0F};
    al = a & 16'hFFFC;
    fr_q.delete();
    for (int i = 0; i < 8; i++) fr_q.push_back(f[8*i +: 8]);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[al[15:2]][8*b +: 8] = d[8*b +: 8];
    if (m[3:0] != 4'd0) exp_wr_q.push_back({al, m[3:0], d});
    exp_tx_q.push_back(8'h06);
  endtask

  task automatic add_read(input logic [15:0] s, input logic [15:0] e);
    logic [39:0] f;
    logic [15:0] as, ae, a;
    logic [31:0] w;
    f  = {e, s, 8'hFF};
    as = s & 16'hFFFC;
    ae = e & 16'hFFFC;
    fr_q.delete();
    for (int i = 0; i < 5; i++) fr_q.push_back(f[8*i +: 8]);
    if (as > ae) begin
      exp_tx_q.push_back(8'h15);
    end else begin
      a = as;
      for (int n = 0; n < 16384; n++) begin
        w = ref_mem[a[15:2]];
        for (int b = 0; b < 4; b++) exp_tx_q.push_back(w[8*b +: 8]);
        exp_re++;
        if (a == ae) break;
        a = a + 16'd4;
      end
    end
  endtask

  task automatic add_single(input logic [7:0] b);
    fr_q.delete();
    fr_q.push_back(b);
    if (b == 8'hA5) exp_tx_q.push_back(8'hA5);
  endtask

  task automatic run_txn(input string tag, input bit rdy_rand, input int long_gap_at);
    int tx0, wr0, re0, sv0, cyc, ntx, nwr;
    rdy_random = rdy_rand;
    tx0 = tx_n; wr0 = wr_n; re0 = re_n; sv0 = stab_viol;
    foreach (fr_q[i]) begin
      if (i == long_gap_at) repeat (TMO - 20) @(negedge clk);
      else repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(fr_q[i]);
    end
    wait_idle(tag, cyc);
    repeat (3) @(negedge clk);
    ntx = tx_n - tx0;
    nwr = wr_n - wr0;
    chk({tag, "/tx_count"}, 64'(ntx), 64'(exp_tx_q.size()));
    foreach (exp_tx_q[i])
      if (i < ntx) chk({tag, "/tx_byte"}, 64'(tx_log[tx0 + i]), 64'(exp_tx_q[i]));
    chk({tag, "/wr_count"}, 64'(nwr), 64'(exp_wr_q.size()));
    foreach (exp_wr_q[i])
      if (i < nwr) chk({tag, "/wr_entry"}, 64'(wr_log[wr0 + i]), 64'(exp_wr_q[i]));
    chk({tag, "/re_count"}, 64'(re_n - re0), 64'(exp_re));
    chk({tag, "/tx_stable"}, 64'(stab_viol - sv0), 64'd0);
    exp_tx_q.delete();
    exp_wr_q.delete();
    exp_re = 0;
  endtask

  initial begin
    int          tx0, wr0, cyc, kind;
    logic [15:0] s, e;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ram_init = 1'b1;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst/tx_valid",  64'(tx_valid),  64'd0);
    chk("rst/tx_data",   64'(tx_data),   64'd0);
    chk("rst/mem_we",    64'(mem_we),    64'd0);
    chk("rst/mem_re",    64'(mem_re),    64'd0);
    chk("rst/mem_addr",  64'(mem_addr),  64'd0);
    chk("rst/mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst/busy",      64'(busy),      64'd0);
    ram_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Full-mask write, then partial-mask write
    add_write(16'h0010, 8'h0F, 32'hDEADBEEF);
    run_txn("wr_full", 1'b0, -1);
    add_write(16'h0020, 8'h05, 32'h11223344);
    run_txn("wr_mask5", 1'b1, -1);
    add_write(16'h0024, 8'h00, 32'hCAFEF00D);
    run_txn("wr_mask0", 1'b0, -1);

    // Two-word burst with backpressure
    add_write(16'h0000, 8'h0F, 32'h03020100);
    run_txn("wr_ram0", 1'b0, -1);
    add_write(16'h0004, 8'h0F, 32'h07060504);
    run_txn("wr_ram4", 1'b0, -1);
    add_read(16'h0000, 16'h0004);
    run_txn("rd_burst", 1'b1, -1);

    // Reversed range -> NAK
    add_read(16'h0008, 16'h0004);
    run_txn("rd_nak", 1'b0, -1);

    // Top-of-address-space single word, no wrap
    add_read(16'hFFFE, 16'hFFFF);
    run_txn("rd_top", 1'b1, -1);

    // Long but sub-timeout gap inside a frame keeps the frame alive
    add_write(16'h0031, 8'hFF, 32'hA5A55A5A);
    run_txn("wr_gap", 1'b0, 3);

    // Timeout: truncated write frame
    fr_q.delete();
    fr_q.push_back(8'h0F); fr_q.push_back(8'h10); fr_q.push_back(8'h00); fr_q.push_back(8'h0F);
    tx0 = tx_n; wr0 = wr_n;
    foreach (fr_q[i]) send_byte(fr_q[i]);
    cyc = 0;
    while (busy !== 1'b0 && cyc < TMO + 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo/busy", 64'(busy), 64'd0);
    chk("tmo/window", 64'((cyc >= TMO - 2) && (cyc <= TMO + 2)), 64'd1);
    repeat (3) @(negedge clk);
    chk("tmo/no_write", 64'(wr_n - wr0), 64'd0);
    chk("tmo/no_tx", 64'(tx_n - tx0), 64'd0);
    add_single(8'hA5);
    run_txn("ping", 1'b1, -1);

    // Reset mid-burst after two bytes
    add_read(16'h0100, 16'h011C);
    exp_tx_q.delete();
    exp_re = 0;
    rdy_random = 1'b0;
    tx0 = tx_n;
    foreach (fr_q[i]) send_byte(fr_q[i]);
    cyc = 0;
    while ((tx_n - tx0) < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid/two_sent", 64'((tx_n - tx0) >= 2), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid/tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_mid/mem_re",   64'(mem_re),   64'd0);
    chk("rst_mid/busy",     64'(busy),     64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    add_read(16'h0000, 16'h0004);
    run_txn("rd_after_rst", 1'b1, -1);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        add_write(16'($urandom_range(0, 63)), 8'($urandom), $urandom);
      end else if (kind < 8) begin
        s = 16'($urandom_range(0, 63));
        e = 16'($urandom_range(0, 63));
        add_read(s, e);
      end else if (kind == 8) begin
        add_single(8'hA5);
      end else begin
        add_single(8'($urandom_range(16, 160)));
      end
      run_txn("rnd", 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
